// File: rtl/uart_img_ctrl.sv
// UART frame loader / image-processing sequencer: captures a SYNC-framed image into a
// frame buffer, kicks the processing core, then streams the processed buffer back out.
module uart_img_ctrl #(
  parameter int          NUM_PIXELS = 64,
  parameter int          ADDR_WIDTH = 6,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int          RX_TIMEOUT = 87000
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Rx_DV,
  input  logic [7:0]            i_Rx_Byte,
  output logic                  o_Tx_DV,
  output logic [7:0]            o_Tx_Byte,
  input  logic                  i_Tx_Active,
  input  logic                  i_Tx_Done,
  output logic                  o_Mem_We,
  output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
  output logic [7:0]            o_Mem_Wdata,
  input  logic [7:0]            i_Mem_Rdata,
  output logic                  o_Proc_Start,
  input  logic                  i_Proc_Done,
  output logic                  o_Busy,
  output logic                  o_Error,
  output logic                  o_Overrun
);
  localparam int                    CW      = $clog2(RX_TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(NUM_PIXELS - 1);
  localparam logic [CW-1:0]         TO_LAST = CW'(RX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, RX_LOAD, PROC_START, PROC_WAIT, TX_FETCH, TX_SEND, TX_WAIT
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  ovr_q, ovr_d;
  logic                  tx_dv_q, tx_dv_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  mem_we;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ovr_d     = ovr_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    case (state_q)
      IDLE: begin
        if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
          addr_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          ovr_d   = 1'b0;
          state_d = RX_LOAD;
        end
      end
      RX_LOAD: begin
        // A byte landing on the expiry cycle wins over the timeout.
        if (i_Rx_DV) begin
          cnt_d = '0;
          if (addr_q == LAST) begin
            addr_d  = '0;
            state_d = PROC_START;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          addr_d  = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PROC_START: state_d = PROC_WAIT;
      PROC_WAIT:  if (i_Proc_Done) state_d = TX_FETCH;
      TX_FETCH:   state_d = TX_SEND;
      TX_SEND: begin
        // Read data for addr_q has been valid since the fetch cycle.
        if (!i_Tx_Active) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = i_Mem_Rdata;
          state_d   = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (i_Tx_Done) begin
          if (addr_q == LAST) begin
            addr_d  = '0;
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = TX_FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (i_Rx_DV && state_q != IDLE && state_q != RX_LOAD) ovr_d = 1'b1;
  end

  assign mem_we       = !i_Reset && state_q == RX_LOAD && i_Rx_DV;
  assign o_Mem_We     = mem_we;
  assign o_Mem_Addr   = addr_q;
  assign o_Mem_Wdata  = mem_we ? i_Rx_Byte : 8'h00;
  assign o_Tx_DV      = tx_dv_q;
  assign o_Tx_Byte    = tx_byte_q;
  assign o_Proc_Start = state_q == PROC_START;
  assign o_Busy       = state_q != IDLE;
  assign o_Error      = err_q;
  assign o_Overrun    = ovr_q;
endmodule

// File: tb/tb_uart_img_ctrl.sv
// Randomized bench for uart_img_ctrl: frame-level reference model (bytes in, bytes+1 out)
// with a frame-buffer RAM, processing core and UART transmitter modelled around the DUT.
module tb_uart_img_ctrl;
  localparam int NP = 4;
  localparam int AW = 2;
  localparam int TO = 200;

  logic          clk = 1'b0;
  logic          i_Reset = 1'b1;
  logic          i_Rx_DV = 1'b0;
  logic [7:0]    i_Rx_Byte = 8'h00;
  logic          o_Tx_DV;
  logic [7:0]    o_Tx_Byte;
  logic          i_Tx_Active = 1'b0;
  logic          i_Tx_Done = 1'b0;
  logic          o_Mem_We;
  logic [AW-1:0] o_Mem_Addr;
  logic [7:0]    o_Mem_Wdata;
  logic [7:0]    i_Mem_Rdata = 8'h00;
  logic          o_Proc_Start;
  logic          i_Proc_Done = 1'b0;
  logic          o_Busy;
  logic          o_Error;
  logic          o_Overrun;

  uart_img_ctrl #(.NUM_PIXELS(NP), .ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .RX_TIMEOUT(TO)) dut (
    .i_Clock(clk), .i_Reset(i_Reset), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
    .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte), .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done),
    .o_Mem_We(o_Mem_We), .o_Mem_Addr(o_Mem_Addr), .o_Mem_Wdata(o_Mem_Wdata),
    .i_Mem_Rdata(i_Mem_Rdata), .o_Proc_Start(o_Proc_Start), .i_Proc_Done(i_Proc_Done),
    .o_Busy(o_Busy), .o_Error(o_Error), .o_Overrun(o_Overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Frame-buffer RAM with one-clock read latency; processing core adds 1 to every pixel.
  logic [7:0] mem [NP];
  initial for (int i = 0; i < NP; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (o_Mem_We) mem[o_Mem_Addr] <= o_Mem_Wdata;
    if (i_Proc_Done) for (int i = 0; i < NP; i++) mem[i] <= mem[i] + 8'd1;
    i_Mem_Rdata <= mem[o_Mem_Addr];
  end

  // Processing-core and transmitter responders.
  int proc_dly = 5;
  int pd_cnt = 0;
  int tx_cnt = 0;
  always @(posedge clk) begin
    #2;
    i_Proc_Done = 1'b0;
    i_Tx_Done   = 1'b0;
    if (i_Reset) begin
      pd_cnt = 0; tx_cnt = 0; i_Tx_Active = 1'b0;
    end else begin
      if (o_Proc_Start) pd_cnt = proc_dly;
      else if (pd_cnt > 0) begin
        pd_cnt--;
        if (pd_cnt == 0) i_Proc_Done = 1'b1;
      end
      if (o_Tx_DV) begin
        tx_cnt = 10; i_Tx_Active = 1'b1;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin i_Tx_Done = 1'b1; i_Tx_Active = 1'b0; end
      end
    end
  end

  // Observation queues, sampled mid-cycle.
  logic [AW-1:0] wa_q [$];
  logic [7:0]    wd_q [$];
  logic [7:0]    tx_q [$];
  int            ps_n = 0;
  int            excl_viol = 0;
  int            stab_viol = 0;
  logic [7:0]    last_tx = 8'h00;
  always @(negedge clk) begin
    if (o_Mem_We) begin wa_q.push_back(o_Mem_Addr); wd_q.push_back(o_Mem_Wdata); end
    if (o_Tx_DV) tx_q.push_back(o_Tx_Byte);
    if (o_Proc_Start) ps_n++;
    if (o_Mem_We && o_Tx_DV) excl_viol++;
    if (i_Reset) last_tx = 8'h00;
    else if (o_Tx_DV) last_tx = o_Tx_Byte;
    else if (o_Tx_Byte !== last_tx) stab_viol++;
  end

  task automatic clr_obs();
    wa_q.delete(); wd_q.delete(); tx_q.delete(); ps_n = 0;
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic send(input logic [7:0] b);
    i_Rx_DV = 1'b1; i_Rx_Byte = b;
    @(posedge clk); #1;
    i_Rx_DV = 1'b0; i_Rx_Byte = 8'($urandom);
  endtask

  task automatic idle(input int n);
    if (n > 0) begin repeat (n) @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_Busy && n < 3000) begin @(posedge clk); #1; n++; end
    chk("idle_timeout", 32'(n < 3000), 1);
  endtask

  task automatic run_frame(input logic [7:0] d [NP], input int slow_idx, input bit inj_ovr);
    clr_obs();
    send(8'hA5);
    for (int i = 0; i < NP; i++) begin
      idle(i == slow_idx ? TO - 1 : int'($urandom_range(0, 8)));
      send(d[i]);
    end
    if (inj_ovr) begin idle(3); send(8'h55); end
    wait_idle();
    chk("n_writes", wa_q.size(), NP);
    for (int i = 0; i < NP && i < wa_q.size(); i++) begin
      chk("wr_addr", wa_q[i], i);
      chk("wr_data", wd_q[i], d[i]);
    end
    chk("proc_start", ps_n, 1);
    chk("n_tx", tx_q.size(), NP);
    for (int i = 0; i < NP && i < tx_q.size(); i++) chk("tx_byte", tx_q[i], 8'(d[i] + 8'd1));
    chk("overrun", o_Overrun, inj_ovr);
    chk("error", o_Error, 0);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_busy"}, o_Busy, 0);
    chk({tag, "_txdv"}, o_Tx_DV, 0);
    chk({tag, "_txbyte"}, o_Tx_Byte, 0);
    chk({tag, "_we"}, o_Mem_We, 0);
    chk({tag, "_wdata"}, o_Mem_Wdata, 0);
    chk({tag, "_addr"}, o_Mem_Addr, 0);
    chk({tag, "_pstart"}, o_Proc_Start, 0);
    chk({tag, "_err"}, o_Error, 0);
    chk({tag, "_ovr"}, o_Overrun, 0);
  endtask

  initial begin
    logic [7:0] d [NP];
    int n;

    repeat (3) @(posedge clk);
    #1; i_Reset = 1'b0;
    chk_zero_outs("rst");

    // Non-sync bytes in IDLE are discarded.
    clr_obs();
    send(8'h00); send(8'h3F);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      send(b);
    end
    idle(2);
    chk("garbage_writes", wa_q.size(), 0);
    chk("garbage_busy", o_Busy, 0);

    d = '{8'h10, 8'h20, 8'h30, 8'h40};
    run_frame(d, -1, 1'b0);
    chk("frame_busy", o_Busy, 0);

    // Sync value inside the frame is ordinary data.
    d = '{8'h10, 8'h20, 8'hA5, 8'h30};
    run_frame(d, -1, 1'b0);

    // Byte on the exact expiry cycle is accepted.
    d = '{8'h01, 8'hFF, 8'h7E, 8'h00};
    run_frame(d, 2, 1'b0);

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NP; i++) d[i] = 8'($urandom);
      proc_dly = int'($urandom_range(1, 20));
      run_frame(d, -1, 1'b0);
    end

    // Byte during PROC_WAIT: dropped, flagged, output unchanged.
    proc_dly = 30;
    for (int i = 0; i < NP; i++) d[i] = 8'($urandom);
    run_frame(d, -1, 1'b1);
    proc_dly = 5;

    // Receive timeout.
    clr_obs();
    send(8'hA5);
    chk("sync_clr_ovr", o_Overrun, 0);
    send(8'h10); send(8'h20);
    idle(TO - 1);
    chk("to_pre_err", o_Error, 0);
    chk("to_pre_busy", o_Busy, 1);
    idle(1);
    chk("to_err", o_Error, 1);
    chk("to_busy", o_Busy, 0);
    idle(20);
    chk("to_pstart", ps_n, 0);
    chk("to_writes", wa_q.size(), 2);
    send(8'hA5);
    chk("sync_clr_err", o_Error, 0);
    for (int i = 0; i < NP; i++) send(8'(8'h60 + i));
    wait_idle();
    chk("post_to_ntx", tx_q.size(), NP);

    // Reset while waiting on the second transmit.
    for (int i = 0; i < NP; i++) d[i] = 8'($urandom);
    clr_obs();
    send(8'hA5);
    for (int i = 0; i < NP; i++) send(d[i]);
    n = 0;
    while (tx_q.size() < 2 && n < 2000) begin @(posedge clk); #1; n++; end
    chk("rst_wait_timeout", 32'(n < 2000), 1);
    idle(3);
    i_Reset = 1'b1;
    idle(1);
    i_Reset = 1'b0;
    chk_zero_outs("midtx");
    idle(60);
    chk("midtx_ntx", tx_q.size(), 2);
    chk("midtx_busy", o_Busy, 0);

    chk("excl_we_txdv", excl_viol, 0);
    chk("txbyte_stable", stab_viol, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_img_ctrl.md
UART_IMG_CTRL -- requirements
Module: uart_img_ctrl

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 64, meaning bytes per frame (2..2**ADDR_WIDTH).
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, meaning frame-buffer address width.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the frame-start marker byte.
REQ-004 SHALL have parameter RX_TIMEOUT, default 87000, meaning the maximum clocks between frame bytes.
REQ-005 SHALL have one clock and a synchronous, active-high reset, listed first: i_Clock  in  1  clock; i_Reset  in  1  reset.
REQ-006 SHALL have i_Rx_DV  in  1  one-cycle received-byte strobe.
REQ-007 SHALL have i_Rx_Byte  in  8  received byte, valid with i_Rx_DV.
REQ-008 SHALL have o_Tx_DV  out  1  one-cycle transmit request.
REQ-009 SHALL have o_Tx_Byte  out  8  byte to transmit.
REQ-010 SHALL have i_Tx_Active  in  1  transmitter busy.
REQ-011 SHALL have i_Tx_Done  in  1  one-cycle transmit-complete strobe.
REQ-012 SHALL have o_Mem_We  out  1  frame-buffer write enable.
REQ-013 SHALL have o_Mem_Addr  out  ADDR_WIDTH  frame-buffer address.
REQ-014 SHALL have o_Mem_Wdata  out  8  frame-buffer write data.
REQ-015 SHALL have i_Mem_Rdata  in  8  read data, one-clock latency after o_Mem_Addr.
REQ-016 SHALL have o_Proc_Start  out  1  one-cycle pulse starting the image-processing core.
REQ-017 SHALL have i_Proc_Done  in  1  processing-complete strobe.
REQ-018 SHALL have o_Busy  out  1  high in every state except IDLE.
REQ-019 SHALL have o_Error  out  1  sticky receive-timeout flag.
REQ-020 SHALL have o_Overrun  out  1  sticky flag for bytes dropped outside the receive phase.

Function
REQ-021 SHALL implement states IDLE, RX_LOAD, PROC_START, PROC_WAIT, TX_FETCH, TX_SEND and TX_WAIT.
REQ-022 IDLE SHALL discard every byte except SYNC_BYTE; on i_Rx_DV with SYNC_BYTE it SHALL clear address, timeout counter, o_Error and o_Overrun, then go to RX_LOAD.
REQ-023 In RX_LOAD, each i_Rx_DV SHALL produce o_Mem_We=1 for exactly that cycle, with o_Mem_Addr=current address and o_Mem_Wdata=i_Rx_Byte; the address SHALL increment the next cycle.
REQ-024 A byte equal to SYNC_BYTE inside RX_LOAD SHALL be stored as ordinary data.
REQ-025 After the write to address NUM_PIXELS-1, the block SHALL go to PROC_START, not wrap the address, and reset the address to 0.
REQ-026 The RX_LOAD timeout counter SHALL reset on every i_Rx_DV; on reaching RX_TIMEOUT it SHALL set o_Error and return to IDLE; the partial frame SHALL not be processed.
REQ-027 PROC_START SHALL assert o_Proc_Start for exactly one cycle, then go to PROC_WAIT.
REQ-028 PROC_WAIT SHALL hold until i_Proc_Done, then go to TX_FETCH.
REQ-029 TX_FETCH SHALL drive o_Mem_Addr for one cycle, then go to TX_SEND.
REQ-030 TX_SEND SHALL wait for i_Tx_Active=0, then pulse o_Tx_DV for one cycle with o_Tx_Byte=i_Mem_Rdata, and go to TX_WAIT.
REQ-031 o_Tx_Byte SHALL remain stable until the next TX_SEND.
REQ-032 TX_WAIT SHALL hold until i_Tx_Done; on the last address it SHALL go to IDLE, otherwise it SHALL increment the address and go to TX_FETCH.
REQ-033 i_Rx_DV in PROC_START through TX_WAIT SHALL be dropped and SHALL set o_Overrun.
REQ-034 i_Rx_DV coinciding with the timeout cycle SHALL be treated as a valid byte; the timeout SHALL not fire in that cycle.
REQ-035 o_Mem_We and o_Tx_DV SHALL never be high in the same cycle; no output is combinational from i_Rx_DV except o_Mem_We, o_Mem_Addr and o_Mem_Wdata.

Reset
REQ-036 i_Reset high at any clock edge SHALL force IDLE, address 0, timeout counter 0, and all outputs 0 (o_Tx_Byte and o_Mem_Wdata = 8'h00), including mid-frame and mid-transmit.
REQ-037 Reset SHALL take priority over every simultaneous input event.

Verification (NUM_PIXELS=4, ADDR_WIDTH=2, RX_TIMEOUT=200)
REQ-038 Bytes A5,10,20,30,40 -> writes 10@0, 20@1, 30@2, 40@3; one o_Proc_Start pulse; no fifth write.
REQ-039 Memory model out[i]=in[i]+1, i_Proc_Done pulse, i_Tx_Done each 10 clocks after o_Tx_DV -> o_Tx_Byte sequence 11,21,31,41, then IDLE with o_Busy=0.
REQ-040 Bytes 00,3F before A5 -> no writes, state IDLE; A5 in data slot 2 -> stored at address 2.
REQ-041 A5,10,20 then 200 idle clocks -> o_Error=1, IDLE, no o_Proc_Start; next A5 clears o_Error.
REQ-042 Byte 55 during PROC_WAIT -> o_Overrun=1, no write, frame output unchanged.
REQ-043 i_Reset during TX_WAIT of byte 2 -> next cycle IDLE, all outputs 0, no further o_Tx_DV.
